// File: rtl/bus_pkg.sv
// Shared bus definitions: packet layout, transaction kinds, driver count.
// Imported by the FIFO RTL and by the verification environment.
package bus_pkg;

  localparam int ID_WIDTH    = 8;
  localparam int max_drivers = 4;

  typedef enum logic [1:0] {
    envio,
    broadcast,
    reset
  } tipo_trans;

  // Packet layout for the default 16-bit bus: {ID, payload}.
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          payload;
  } pkt16_t;

  // Builds a packet of any width from its ID and payload fields.
  function automatic logic [63:0] mk_pkt(
    input logic [ID_WIDTH-1:0] id,
    input logic [55:0]         payload,
    input int                  width
  );
    logic [63:0] p;
    p = 64'(payload) & ((64'd1 << (width - ID_WIDTH)) - 64'd1);
    p = p | (64'(id) << (width - ID_WIDTH));
    return p;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// First-word-fall-through packet FIFO. Ports: clk, rst (async high),
// push/D_push write side, pop/D_pop read side, full, pndng, count.
module bus_fifo
  import bus_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [width-1:0]           D_push,
  input  logic                       pop,
  output logic [width-1:0]           D_pop,
  output logic                       full,
  output logic                       pndng,
  output logic [$clog2(depth):0]     count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(depth));
  assign pndng = (cnt != '0);
  assign count = cnt;

  // A full queue still accepts a push when a pop frees the head slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && pndng;

  assign D_pop = pndng ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; it is only observed while pndng is high.
  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem[wr_ptr] <= D_push;
  end

endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo: vector table plus
// hand sequences for wrap, async reset and random packets.
module tb_bus_fifo;

  logic        clk = 0;
  logic        rst;
  logic        push;
  logic        pop;
  logic [15:0] D_push;
  logic [15:0] D_pop;
  logic        full;
  logic        pndng;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        p;
    logic        q;
    logic [15:0] d;
    logic [15:0] ed;
    logic        ef;
    logic        ep;
    logic [3:0]  ec;
  } vec_t;

  vec_t vec[$];
  logic [15:0] model[$];

  bus_fifo #(.width(16), .depth(8)) dut (
    .clk(clk), .rst(rst), .push(push), .D_push(D_push),
    .pop(pop), .D_pop(D_pop), .full(full), .pndng(pndng),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] ed,
                         input logic ef, input logic ep,
                         input logic [3:0] ec);
    chk({nm, ".dout"},  64'(D_pop), 64'(ed));
    chk({nm, ".full"},  64'(full),  64'(ef));
    chk({nm, ".pndng"}, 64'(pndng), 64'(ep));
    chk({nm, ".count"}, 64'(count), 64'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic q,
                     input logic [15:0] d, input logic [15:0] ed,
                     input logic ef, input logic ep,
                     input logic [3:0] ec);
    vec_t v;
    v.p = p; v.q = q; v.d = d;
    v.ed = ed; v.ef = ef; v.ep = ep; v.ec = ec;
    vec.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1; push = 0; pop = 0; D_push = '0;
    step();
    rst = 0;
    step();
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; D_push = '0;
    step();
    chk_all("rst_hold", 16'h0, 0, 0, 4'd0);
    rst = 0;
    step();
    chk_all("rst_after", 16'h0, 0, 0, 4'd0);

    // single push/pop, pop on empty, push+pop on empty
    add(1, 0, 16'h03A5, 16'h03A5, 0, 1, 4'd1);
    add(0, 1, 16'h0000, 16'h0000, 0, 0, 4'd0);
    add(0, 1, 16'h0000, 16'h0000, 0, 0, 4'd0);
    add(1, 1, 16'h0111, 16'h0111, 0, 1, 4'd1);
    add(0, 1, 16'h0000, 16'h0000, 0, 0, 4'd0);
    // fill, drop on full, drain in order
    for (int i = 0; i < 8; i++)
      add(1, 0, 16'h0100 + 16'(i), 16'h0100, i == 7, 1, 4'(i + 1));
    add(1, 0, 16'h0FFF, 16'h0100, 1, 1, 4'd8);
    for (int i = 0; i < 8; i++)
      add(0, 1, 16'h0, (i < 7) ? 16'h0101 + 16'(i) : 16'h0,
          0, i < 7, 4'(7 - i));
    // refill, then push+pop while full
    for (int i = 0; i < 8; i++)
      add(1, 0, 16'h0200 + 16'(i), 16'h0200, i == 7, 1, 4'(i + 1));
    add(1, 1, 16'h0AAA, 16'h0201, 1, 1, 4'd8);
    for (int i = 0; i < 8; i++)
      add(0, 1, 16'h0,
          (i < 6) ? 16'h0202 + 16'(i) : ((i == 6) ? 16'h0AAA : 16'h0),
          0, i < 7, 4'(7 - i));

    foreach (vec[k]) begin
      push = vec[k].p; pop = vec[k].q; D_push = vec[k].d;
      step();
      chk_all($sformatf("vec%0d", k), vec[k].ed, vec[k].ef,
              vec[k].ep, vec[k].ec);
    end
    push = 0; pop = 0;

    // wrap: hold count at 4 with simultaneous push/pop
    do_reset();
    model.delete();
    for (int i = 0; i < 4; i++) begin
      push = 1; D_push = 16'h0300 + 16'(i);
      model.push_back(D_push);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      push = 1; pop = 1; D_push = 16'h0310 + 16'(k);
      model.push_back(D_push);
      void'(model.pop_front());
      step();
      chk_all($sformatf("wrap%0d", k), model[0], 0, 1, 4'd4);
    end
    push = 0; pop = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_drain%0d", k), 64'(D_pop), 64'(model[0]));
      void'(model.pop_front());
      step();
    end
    pop = 0;
    chk_all("wrap_empty", 16'h0, 0, 0, 4'd0);

    // async reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      push = 1; D_push = 16'h0400 + 16'(i);
      step();
    end
    push = 0;
    chk_all("pre_arst", 16'h0400, 0, 1, 4'd3);
    @(negedge clk);
    push = 1; pop = 1; D_push = 16'h0EEE;
    rst = 1;
    #1;
    chk_all("arst_now", 16'h0, 0, 0, 4'd0);
    step();
    chk_all("arst_hold", 16'h0, 0, 0, 4'd0);
    push = 0; pop = 0;
    rst = 0;
    step();
    chk_all("arst_after", 16'h0, 0, 0, 4'd0);

    // random packets with random gaps
    model.delete();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] id;
      logic [7:0] pl;
      id = 8'($urandom);
      pl = 8'($urandom);
      repeat ($urandom_range(0, 10)) step();
      push = 1; D_push = {id, pl};
      model.push_back({id, pl});
      step();
      push = 0;
    end
    chk("rnd_count", 64'(count), 64'd3);
    pop = 1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rnd%0d", k), 64'(D_pop), 64'(model[k]));
      step();
    end
    pop = 0;
    chk_all("rnd_empty", 16'h0, 0, 0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
